cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle sequencer for the 3-bit-opcode CPU core. It steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. It owns the program counter and instruction register, and handles the instruction-memory handshake. It qualifies the instruction decoder's outputs into single-cycle register-file write and ALU/immediate select strobes. The block sits between instruction memory, the decoder and the register-file/ALU datapath.

## Interface
- OPCODE, 3, opcode width; opcode = ir[INSTR_W-1 -: OPCODE]
- INSTR_W, 16, instruction width
- PC_W, 8, program counter width
- TIMEOUT, 15, max cycles waiting for imem_valid before fault (>=1)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- run  input  1  level; enables instruction execution
- imem_req  output  1  fetch request, held until imem_valid
- imem_addr  output  PC_W  fetch address (= pc)
- imem_valid  input  1  fetch data valid this cycle
- imem_rdata  input  INSTR_W  fetched instruction
- ir  output  INSTR_W  instruction register
- opcode  output  OPCODE  opcode field of ir, to decoder
- dec_reg_wr_en, dec_alu_op, dec_imm_op  input  1 each  decoder outputs
- rf_wr_en  output  1  register-file write strobe, WRITEBACK only
- alu_op  output  1  registered ALU op, valid EXECUTE and WRITEBACK
- imm_sel  output  1  registered immediate select, valid EXECUTE and WRITEBACK
- pc  output  PC_W  program counter
- busy  output  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
- halted  output  1  high in HALTED
- fault  output  1  high in FAULT

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, FAULT.
- Reset values: state IDLE, pc 0, ir 0, timeout counter 0, alu_op/imm_sel 0, all strobes/flags 0.
- IDLE: when run=1, go to FETCH; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_valid, load ir from imem_rdata and go to DECODE.
  - Each cycle without valid increments the timeout counter. When the counter reaches TIMEOUT, go to FAULT.
  - The counter clears on entry to FETCH.
- DECODE: one cycle; opcode drives the decoder combinationally.
  - At the end of the cycle, register alu_op <= dec_alu_op, imm_sel <= dec_imm_op, wb_pending <= dec_reg_wr_en | dec_imm_op.
  - Opcode 3'b111 is HALT: go to HALTED. No write, pc unchanged.
- EXECUTE: one cycle; the datapath computes using alu_op/imm_sel.
- WRITEBACK: one cycle.
  - rf_wr_en = wb_pending.
  - pc <= pc + 1, modulo 2^PC_W (0xFF wraps to 0x00).
  - Next state FETCH if run=1, else IDLE.
- run only gates the start of an instruction. Dropping run mid-instruction completes that instruction, then returns to IDLE.
- HALTED: halted=1. Exit to IDLE when run=0. pc is retained.
- FAULT: fault=1. Only reset exits this state.
- Undefined opcodes retire as no-ops: wb_pending follows the decoder, and pc increments.

## Timing
- Zero-wait fetch (imem_valid in the first FETCH cycle): 4 cycles per instruction, back to back with run held high.
- Each wait cycle adds 1.
- rf_wr_en is exactly one cycle wide, 3 cycles after the imem_valid cycle.
- imem_rdata is sampled only in the cycle imem_valid=1 while in FETCH. imem_valid outside FETCH is ignored.
- Asynchronous reset mid-instruction: state, pc and all outputs go to reset values immediately. No partial write.
- Fault boundary: valid arriving in the same cycle the counter hits TIMEOUT is accepted; valid wins over fault.

## Configuration
- CPU_SEQ_RETIRE_CNT_EN defined:
  - Adds output retire_cnt [15:0], reset 0.
  - It increments in every WRITEBACK cycle and wraps at 0xFFFF.
  - HALT and faults do not count.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, run=1, zero-wait memory returning ADD (opcode 000) at pc 0 and 1 -> imem_req in cycles 1 and 5, rf_wr_en pulses in cycles 4 and 8, pc=2 after cycle 8.
- MOVI (opcode 001) with 3 wait cycles -> imm_sel=1 in EXECUTE/WRITEBACK, rf_wr_en one pulse, instruction takes 7 cycles.
- HALT (opcode 111) at pc 5 -> halted=1, rf_wr_en never asserted, pc stays 5; run=0 -> IDLE.
- imem_valid never asserted, TIMEOUT=15 -> fault=1 after 15 wait cycles; recovery only via rst_n.
- pc=0xFF, ADD executes -> pc wraps to 0x00; with CPU_SEQ_RETIRE_CNT_EN, retire_cnt increments by 1.
- rst_n low during EXECUTE -> outputs go to 0 immediately without a clock edge, no rf_wr_en; restart fetches from pc 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the 3-bit-opcode core.
// Optional retire counter output enabled by defining CPU_SEQ_RETIRE_CNT_EN.
module cpu_sequencer #(
  parameter int unsigned OPCODE  = 3,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [OPCODE-1:0]  opcode,
  input  logic               dec_reg_wr_en,
  input  logic               dec_alu_op,
  input  logic               dec_imm_op,
  output logic               rf_wr_en,
  output logic               alu_op,
  output logic               imm_sel,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic               fault
`ifdef CPU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]        retire_cnt
`endif
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);
  localparam logic [OPCODE-1:0] OpHalt = '1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalted,
    StFault
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [TmoW-1:0]    tmo_q, tmo_inc;
  logic               alu_op_q, imm_sel_q, wb_pending_q;
  logic               imem_req_q, rf_wr_en_q, busy_q, halted_q, fault_q;

  assign opcode    = ir_q[INSTR_W-1 -: OPCODE];
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign imem_req  = imem_req_q;
  assign rf_wr_en  = rf_wr_en_q;
  assign alu_op    = alu_op_q;
  assign imm_sel   = imm_sel_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

  always_comb begin
    state_d = state_q;
    tmo_inc = tmo_q + TmoW'(1);
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        // A valid arriving on the final wait cycle still wins over the fault.
        if (imem_valid) begin
          state_d = StDecode;
        end else if (tmo_inc == TmoMax) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        state_d = (opcode == OpHalt) ? StHalted : StExecute;
      end
      StExecute: begin
        state_d = StWriteback;
      end
      StWriteback: begin
        state_d = run ? StFetch : StIdle;
      end
      StHalted: begin
        if (!run) state_d = StIdle;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      tmo_q        <= '0;
      alu_op_q     <= 1'b0;
      imm_sel_q    <= 1'b0;
      wb_pending_q <= 1'b0;
      imem_req_q   <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter is held at zero outside FETCH, so every FETCH entry starts fresh.
      tmo_q   <= (state_q == StFetch && !imem_valid) ? tmo_inc : '0;
      if (state_q == StFetch && imem_valid) begin
        ir_q <= imem_rdata;
      end
      if (state_q == StDecode) begin
        alu_op_q     <= dec_alu_op;
        imm_sel_q    <= dec_imm_op;
        wb_pending_q <= (opcode != OpHalt) && (dec_reg_wr_en || dec_imm_op);
      end
      if (state_q == StWriteback) begin
        pc_q <= pc_q + PC_W'(1);
      end
      // Outputs are registered from the next state so they align with it.
      imem_req_q <= (state_d == StFetch);
      rf_wr_en_q <= (state_d == StWriteback) && wb_pending_q;
      busy_q     <= (state_d inside {StFetch, StDecode, StExecute, StWriteback});
      halted_q   <= (state_d == StHalted);
      fault_q    <= (state_d == StFault);
    end
  end

`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_q;

  assign retire_cnt = retire_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (state_q == StWriteback) begin
      retire_q <= retire_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a small decoder and memory model.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        valid;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic        dec_reg_wr_en, dec_alu_op, dec_imm_op;
  logic        rf_wr_en, alu_op, imm_sel;
  logic [7:0]  pc;
  logic        busy, halted, fault;
`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  logic [15:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  cpu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (valid),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .opcode       (opcode),
    .dec_reg_wr_en(dec_reg_wr_en),
    .dec_alu_op   (dec_alu_op),
    .dec_imm_op   (dec_imm_op),
    .rf_wr_en     (rf_wr_en),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault)
`ifdef CPU_SEQ_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_rdata = mem[imem_addr];

  // ADD: write + ALU; MOVI: write + immediate; everything else: no effect.
  always_comb begin
    {dec_reg_wr_en, dec_alu_op, dec_imm_op} = 3'b000;
    case (opcode)
      3'b000:  {dec_reg_wr_en, dec_alu_op, dec_imm_op} = 3'b110;
      3'b001:  {dec_reg_wr_en, dec_alu_op, dec_imm_op} = 3'b101;
      default: {dec_reg_wr_en, dec_alu_op, dec_imm_op} = 3'b000;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000;
    mem[0] = 16'h0123;
    mem[1] = 16'h1234;
    mem[2] = 16'h2A55;
    mem[3] = 16'h8000;
    mem[4] = 16'h0456;
    mem[5] = 16'hE000;
    mem[255] = 16'h0FED;

    rst_n = 1'b1;
    run   = 1'b0;
    valid = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_req", imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {halted, fault, rf_wr_en, alu_op, imm_sel}, 0);
`ifdef CPU_SEQ_RETIRE_CNT_EN
    check("rst_retire", retire_cnt, 0);
`endif

    // Two zero-wait ADDs.
    rst_n = 1'b1;
    run   = 1'b1;
    check("c0_req", imem_req, 0);
    step();
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, 0);
    check("c1_busy", busy, 1);
    step();
    check("c2_ir", ir, 16'h0123);
    check("c2_req", imem_req, 0);
    step();
    check("c3_alu", {alu_op, imm_sel, rf_wr_en}, 3'b100);
    step();
    check("c4_wr", rf_wr_en, 1);
    check("c4_pc", pc, 0);
    step();
    check("c5_req", imem_req, 1);
    check("c5_pc", pc, 1);
    check("c5_wr", rf_wr_en, 0);
    repeat (3) step();
    check("c8_wr", rf_wr_en, 1);
    check("c8_ir", ir, 16'h1234);
    step();
    check("c9_pc", pc, 2);

    // MOVI with three wait cycles.
    valid = 1'b0;
    step();
    step();
    check("movi_wait_req", imem_req, 1);
    step();
    valid = 1'b1;
    step();
    check("movi_ir", ir, 16'h2A55);
    step();
    check("movi_ex_sel", {alu_op, imm_sel}, 2'b01);
    check("movi_ex_wr", rf_wr_en, 0);
    step();
    check("movi_wb", {rf_wr_en, imm_sel}, 2'b11);
    step();
    check("movi_next_pc", pc, 3);
    check("movi_next_req", imem_req, 1);

    // Undefined opcode retires as a no-op.
    repeat (3) step();
    check("undef_wb_wr", rf_wr_en, 0);
    check("undef_wb_busy", busy, 1);
    step();
    check("undef_pc", pc, 4);

    // Drop run mid-instruction: ADD at pc 4 completes, then IDLE.
    step();
    run = 1'b0;
    step();
    step();
    check("drop_wb_wr", rf_wr_en, 1);
    step();
    check("drop_idle", {busy, imem_req}, 2'b00);
    check("drop_pc", pc, 5);
    step();
    check("drop_stay", imem_req, 0);

    // HALT at pc 5.
    run = 1'b1;
    step();
    step();
    check("halt_opcode", opcode, 3'b111);
    step();
    check("halt_flags", {halted, busy, rf_wr_en}, 3'b100);
    step();
    check("halt_hold", {halted, rf_wr_en}, 2'b10);
    check("halt_pc", pc, 5);
    run = 1'b0;
    step();
    check("halt_exit", {halted, busy}, 2'b00);
    check("halt_exit_pc", pc, 5);

    // Asynchronous reset during EXECUTE.
    mem[5] = 16'h0789;
    run = 1'b1;
    repeat (3) step();
    check("are_ex_alu", alu_op, 1);
    #2 rst_n = 1'b0;
    #1;
    check("are_pc", pc, 0);
    check("are_ir", ir, 0);
    check("are_out", {busy, alu_op, imm_sel, rf_wr_en, imem_req}, 0);
    @(posedge clk);
    #1;
    check("are_no_wr", rf_wr_en, 0);
    rst_n = 1'b1;
    step();
    check("are_refetch", {imem_req, imem_addr}, {1'b1, 8'h00});

    // Run up to pc 0xFF, then ADD there wraps pc.
    for (int i = 0; i < 1200 && pc !== 8'hFF; i++) step();
    check("wrap_reach", pc, 8'hFF);
    check("wrap_req", imem_req, 1);
    run = 1'b0;
    repeat (3) step();
    check("wrap_wb_wr", rf_wr_en, 1);
    check("wrap_wb_pc", pc, 8'hFF);
    step();
    check("wrap_pc", pc, 8'h00);
    check("wrap_idle", busy, 0);
`ifdef CPU_SEQ_RETIRE_CNT_EN
    check("wrap_retire", retire_cnt, 16'd256);
`endif

    // Valid on the 15th FETCH cycle is still accepted.
    valid = 1'b0;
    run   = 1'b1;
    step();
    repeat (14) step();
    check("bnd_req", {imem_req, fault}, 2'b10);
    valid = 1'b1;
    step();
    check("bnd_accept", {busy, fault}, 2'b10);
    check("bnd_ir", ir, 16'h0123);
    run = 1'b0;
    repeat (3) step();
    check("bnd_pc", pc, 1);

    // Memory never answers: fault after 15 wait cycles.
    valid = 1'b0;
    run   = 1'b1;
    step();
    repeat (14) step();
    check("tmo_c15", {imem_req, fault}, 2'b10);
    step();
    check("tmo_fault", {fault, imem_req, busy}, 3'b100);
    valid = 1'b1;
    run   = 1'b0;
    repeat (3) step();
    check("tmo_sticky", fault, 1);
    check("tmo_pc", pc, 1);
    rst_n = 1'b0;
    #1;
    check("tmo_reset", {fault, pc}, 9'h000);
    rst_n = 1'b1;
    step();
    check("tmo_after", {fault, busy}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
